// File: rtl/uart_intpt_pkg.sv
// Shared types and defaults for the UART interrupt controller.
// Holds the IIR interrupt-ID encoding and the timeout counter width.
package uart_intpt_pkg;

    localparam int TOUT_W_DEF = 10;

    typedef enum logic [3:0] {
        IIR_MS   = 4'b0000,
        IIR_NONE = 4'b0001,
        IIR_THRE = 4'b0010,
        IIR_RDA  = 4'b0100,
        IIR_RLS  = 4'b0110,
        IIR_CTO  = 4'b1100
    } iir_id_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// RX character-timeout detector: bit-time counter, threshold
// comparator and the sticky timeout-pending flag.
module uart_rx_timeout
    import uart_intpt_pkg::*;
#(
    parameter int TOUT_W = TOUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_tick,
    input  logic              fifo_en,
    input  logic              rx_empty,
    input  logic              rx_push,
    input  logic              rx_pop,
    input  logic [TOUT_W-1:0] tout_limit,
    output logic              tout_pend
);

    logic [TOUT_W-1:0] r_cnt;
    logic              r_pend;
    logic              w_cnt_clr;
    logic              w_pend_clr;
    logic              w_cnt_sat;
    logic              w_hit;

    // Any FIFO activity, an empty FIFO or non-FIFO mode restarts the count;
    // a push restarts the count but leaves an already pending timeout alone.
    assign w_cnt_clr  = rx_push | rx_pop | rx_empty | ~fifo_en;
    assign w_pend_clr = rx_pop | rx_empty | ~fifo_en;
    assign w_cnt_sat  = &r_cnt;
    assign w_hit      = (tout_limit != '0) && (r_cnt >= tout_limit);

    // Bit-time counter, saturating so a long idle never wraps back below the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (bit_tick && !w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, raised once the count reaches a non-zero limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (w_pend_clr) begin
            r_pend <= 1'b0;
        end else if (w_hit) begin
            r_pend <= 1'b1;
        end
    end

    assign tout_pend = r_pend;

endmodule

// File: rtl/uart_intpt_ctrl.sv
// Prioritised UART interrupt controller with 16550-style IIR ID.
// Holds the THRE pending flag, the priority encoder and output registers.
module uart_intpt_ctrl
    import uart_intpt_pkg::*;
#(
    parameter int TOUT_W = TOUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_tick,
    input  logic              thre,
    input  logic              etbei,
    input  logic              pe,
    input  logic              fe,
    input  logic              bi,
    input  logic              oe,
    input  logic              elsi,
    input  logic              dr,
    input  logic              erbi,
    input  logic              below_level,
    input  logic              fifo_en,
    input  logic              rx_empty,
    input  logic              rx_push,
    input  logic              rx_pop,
    input  logic              dcts,
    input  logic              ddsr,
    input  logic              teri,
    input  logic              ddcd,
    input  logic              edssi,
    input  logic [TOUT_W-1:0] tout_limit,
    input  logic              iir_rd,
    input  logic              thr_wr,
    output logic [3:0]        iir_id,
    output logic              uart_intpt
);

    logic    r_thre_d;
    logic    r_etbei_d;
    logic    r_thre_pend;
    iir_id_t r_iir_id;
    logic    r_intpt;

    logic    w_tout_pend;
    logic    w_thre_set;
    logic    w_thre_rd_clr;
    logic    w_thre_live;
    logic    w_rls;
    logic    w_rda;
    logic    w_cto;
    logic    w_thr;
    logic    w_ms;
    iir_id_t w_next_id;

    uart_rx_timeout #(
        .TOUT_W (TOUT_W)
    ) u_rx_timeout (
        .clk        (clk),
        .rst        (rst),
        .bit_tick   (bit_tick),
        .fifo_en    (fifo_en),
        .rx_empty   (rx_empty),
        .rx_push    (rx_push),
        .rx_pop     (rx_pop),
        .tout_limit (tout_limit),
        .tout_pend  (w_tout_pend)
    );

    // A new THRE event is thre rising, or the enable rising while thre is high.
    assign w_thre_set    = (thre & ~r_thre_d) | (etbei & ~r_etbei_d & thre);
    assign w_thre_rd_clr = iir_rd & (r_iir_id == IIR_THRE);

    // Clears act on the source in the same cycle so the ID drops one edge
    // after the IIR read or THR write; a fresh set still takes an extra edge.
    assign w_thre_live = r_thre_pend & ~thr_wr & ~(w_thre_rd_clr & ~w_thre_set);

    assign w_rls = (pe | fe | bi | oe) & elsi;
    assign w_rda = dr & erbi & (~fifo_en | ~below_level);
    assign w_cto = w_tout_pend & erbi & fifo_en;
    assign w_thr = w_thre_live & etbei;
    assign w_ms  = (dcts | ddsr | teri | ddcd) & edssi;

    // Registered edge detectors for thre and etbei.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thre_d  <= 1'b0;
            r_etbei_d <= 1'b0;
        end else begin
            r_thre_d  <= thre;
            r_etbei_d <= etbei;
        end
    end

    // THRE pending: THR write beats a new event, a new event beats an IIR read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thre_pend <= 1'b0;
        end else if (thr_wr) begin
            r_thre_pend <= 1'b0;
        end else if (w_thre_set) begin
            r_thre_pend <= 1'b1;
        end else if (w_thre_rd_clr) begin
            r_thre_pend <= 1'b0;
        end
    end

    // Fixed-priority selection of the highest active source.
    always_comb begin
        w_next_id = IIR_NONE;
        if (w_rls) begin
            w_next_id = IIR_RLS;
        end else if (w_rda) begin
            w_next_id = IIR_RDA;
        end else if (w_cto) begin
            w_next_id = IIR_CTO;
        end else if (w_thr) begin
            w_next_id = IIR_THRE;
        end else if (w_ms) begin
            w_next_id = IIR_MS;
        end
    end

    // Output registers for the IIR ID and the interrupt request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iir_id <= IIR_NONE;
            r_intpt  <= 1'b0;
        end else begin
            r_iir_id <= w_next_id;
            r_intpt  <= (w_next_id != IIR_NONE);
        end
    end

    assign iir_id     = r_iir_id;
    assign uart_intpt = r_intpt;

endmodule

// File: tb/tb_uart_intpt_ctrl.sv
// Directed self-checking bench for uart_intpt_ctrl.
// Expected IDs are hand-derived from the source priority and latencies.
module tb_uart_intpt_ctrl;

    localparam int TW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_tick = 0, thre = 0, etbei = 0;
    logic          pe = 0, fe = 0, bi = 0, oe = 0, elsi = 0;
    logic          dr = 0, erbi = 0, below_level = 0, fifo_en = 0;
    logic          rx_empty = 1, rx_push = 0, rx_pop = 0;
    logic          dcts = 0, ddsr = 0, teri = 0, ddcd = 0, edssi = 0;
    logic [TW-1:0] tout_limit = '0;
    logic          iir_rd = 0, thr_wr = 0;
    logic [3:0]    iir_id;
    logic          uart_intpt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_intpt_ctrl #(.TOUT_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_tick    (bit_tick),
        .thre        (thre),
        .etbei       (etbei),
        .pe          (pe),
        .fe          (fe),
        .bi          (bi),
        .oe          (oe),
        .elsi        (elsi),
        .dr          (dr),
        .erbi        (erbi),
        .below_level (below_level),
        .fifo_en     (fifo_en),
        .rx_empty    (rx_empty),
        .rx_push     (rx_push),
        .rx_pop      (rx_pop),
        .dcts        (dcts),
        .ddsr        (ddsr),
        .teri        (teri),
        .ddcd        (ddcd),
        .edssi       (edssi),
        .tout_limit  (tout_limit),
        .iir_rd      (iir_rd),
        .thr_wr      (thr_wr),
        .iir_id      (iir_id),
        .uart_intpt  (uart_intpt)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bt();
        bit_tick = 1'b1;
        cyc();
        bit_tick = 1'b0;
        cyc();
    endtask

    task automatic chk_id(input string tag, input logic [3:0] exp_id);
        chk(tag, 8'(iir_id), 8'(exp_id));
        chk({tag, "_irq"}, 8'(uart_intpt), 8'(exp_id != 4'b0001));
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk_id("rst", 4'b0001);
        cyc();
        chk_id("idle", 4'b0001);

        // THRE rising: pending at edge 1, outputs at edge 2
        etbei = 1'b1;
        thre  = 1'b1;
        cyc();
        chk_id("thre_lat1", 4'b0001);
        cyc();
        chk_id("thre_set", 4'b0010);
        iir_rd = 1'b1;
        cyc();
        iir_rd = 1'b0;
        chk_id("thre_rdclr", 4'b0001);
        cyc(2);
        chk_id("thre_stay", 4'b0001);

        // read coincident with a new THRE edge: set wins
        thre = 1'b0;
        cyc();
        thre = 1'b1;
        cyc(2);
        chk_id("thre_re", 4'b0010);
        thre = 1'b0;
        cyc();
        chk_id("thre_hold", 4'b0010);
        thre   = 1'b1;
        iir_rd = 1'b1;
        cyc();
        iir_rd = 1'b0;
        chk_id("rd_vs_set", 4'b0010);
        cyc();
        chk_id("rd_vs_set2", 4'b0010);
        thr_wr = 1'b1;
        cyc();
        thr_wr = 1'b0;
        chk_id("thr_wr", 4'b0001);
        cyc();
        chk_id("thr_wr2", 4'b0001);
        thre  = 1'b0;
        etbei = 1'b0;
        cyc();

        // priority RLS over RDA
        fe = 1; elsi = 1; dr = 1; erbi = 1; fifo_en = 0;
        cyc();
        chk_id("rls", 4'b0110);
        fe = 0;
        cyc();
        chk_id("rda", 4'b0100);
        dr = 0;
        cyc();
        chk_id("rda_off", 4'b0001);

        // trigger level qualifier in FIFO mode
        fifo_en = 1; dr = 1; below_level = 1;
        cyc(2);
        chk_id("below_lvl", 4'b0001);
        below_level = 0;
        cyc();
        chk_id("at_lvl", 4'b0100);
        dr = 0; below_level = 1;
        cyc();
        chk_id("lvl_off", 4'b0001);

        // character timeout with a push restarting the count
        tout_limit = 10'd40;
        rx_empty   = 1'b0;
        repeat (38) bt();
        bit_tick = 1'b1;
        rx_push  = 1'b1;
        cyc();
        bit_tick = 1'b0;
        rx_push  = 1'b0;
        cyc();
        chk_id("push_rst", 4'b0001);
        repeat (39) bt();
        cyc(2);
        chk_id("cto_39", 4'b0001);
        bt();
        chk_id("cto_lat", 4'b0001);
        cyc();
        chk_id("cto", 4'b1100);
        rx_pop = 1'b1;
        cyc();
        rx_pop = 1'b0;
        cyc();
        chk_id("cto_pop", 4'b0001);

        // modem status, then asynchronous reset mid-count
        ddcd  = 1'b1;
        edssi = 1'b1;
        cyc();
        chk_id("ms", 4'b0000);
        repeat (5) bt();
        #3 rst = 1'b1;
        #1;
        chk_id("async_rst", 4'b0001);
        cyc(2);
        rst = 1'b0;
        chk_id("rel", 4'b0001);
        cyc();
        chk_id("ms_again", 4'b0000);
        ddcd = 1'b0;
        cyc();
        chk_id("ms_off", 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_intpt_ctrl.md
# uart_intpt_ctrl

Registered, prioritised UART interrupt controller with 16550-style identification. It replaces the flat OR-of-sources interrupt with five sources: receiver line status, RX data available, character timeout, THR empty and modem status. It adds a sticky THRE pending flag that is cleared on read, a character-timeout counter, and a FIFO-mode qualifier. It sits between the LSR/MSR/FIFO logic and the register file, and drives `uart_intpt` and the IIR interrupt-ID field.

## Interface
- `TOUT_W`, 10: width of the character-timeout counter and of `tout_limit`.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `bit_tick` in 1: one-cycle pulse per received bit time; clocks the timeout counter.
- `thre`, `etbei` in 1: THR empty; enable for the THRE interrupt.
- `pe`, `fe`, `bi`, `oe`, `elsi` in 1: sticky LSR error flags; enable for line-status interrupts.
- `dr`, `erbi`, `below_level` in 1: data ready; RX interrupt enable; RX FIFO below trigger level.
- `fifo_en` in 1: FIFO mode (FCR[0]).
- `rx_empty`, `rx_push`, `rx_pop` in 1: RX FIFO empty; write strobe; read (RBR) strobe.
- `dcts`, `ddsr`, `teri`, `ddcd`, `edssi` in 1: MSR delta flags; enable for modem-status interrupts.
- `tout_limit` in `TOUT_W`: timeout threshold in bit times (normally 4 character times); 0 disables the timeout.
- `iir_rd` in 1: IIR read strobe.
- `thr_wr` in 1: THR write strobe.
- `iir_id` out 4: registered interrupt ID.
- `uart_intpt` out 1: registered interrupt request.

## Operation
Source conditions, in priority order (highest first), evaluated each cycle:
- **RLS** (0110): `(pe|fe|bi|oe) & elsi`. Level-sensitive; clearing belongs to the LSR read upstream.
- **RDA** (0100): `dr & erbi & (~fifo_en | ~below_level)`.
- **CTO** (1100): `tout_pend & erbi & fifo_en`.
- **THRE** (0010): `thre_pend & etbei`.
- **MS** (0000): `(dcts|ddsr|teri|ddcd) & edssi`.
- **NONE** (0001): no source active.

THRE pending flag `thre_pend`:
- Set on a rising edge of `thre`.
- Set on a rising edge of `etbei` while `thre`=1.
- Cleared by `thr_wr`.
- Cleared by `iir_rd` when the registered `iir_id`==THRE in that cycle.
- Set and `iir_rd` in the same cycle: set wins.
- `thr_wr` and set in the same cycle: `thr_wr` wins.
- Edge detection uses registered copies of `thre` and `etbei`, both reset to 0.

Timeout counter `tout_cnt`:
- Reset to 0 when `rx_push`, `rx_pop`, `rx_empty` or `~fifo_en` is asserted.
- Otherwise increments on `bit_tick` and saturates at all-ones.
- When `tout_limit`≠0 and `tout_cnt`>=`tout_limit`, `tout_pend` is set.
- `tout_pend` is cleared by `rx_pop`, `rx_empty` or `~fifo_en`.
- `rx_push` alone does not clear `tout_pend`.
- Comparison is unsigned over `TOUT_W` bits with no wrap.

Outputs:
- `iir_id` takes the highest-priority active source.
- `uart_intpt` = (next `iir_id` != NONE).

## Timing
- Reset values:
  - `iir_id`=0001, `uart_intpt`=0.
  - `thre_pend`=0, `tout_cnt`=0, `tout_pend`=0.
  - Edge registers = 0.
- Latency:
  - A level source asserted in cycle N appears on `iir_id`/`uart_intpt` after edge N+1.
  - A source deasserted in cycle N drops its outputs after edge N+1.
  - `thre` rising in cycle N: `thre_pend` is set at edge N+1 and the outputs update at edge N+2.
- Timeout: with `tout_limit`=L and no FIFO activity, `tout_pend` sets at the edge after the L-th `bit_tick`. The outputs follow one edge later.
- `iir_rd` clears are evaluated against the `iir_id` value held during the strobe, never the next value.
- Reset may assert at any time: all state returns to reset values asynchronously. No interrupt is issued on the first cycle after release.

## Structure
- Package `uart_intpt_pkg` holds:
  - `typedef enum logic [3:0] iir_id_t` with values IIR_RLS, IIR_RDA, IIR_CTO, IIR_THRE, IIR_MS and IIR_NONE.
  - Default `TOUT_W` localparam.
- Sub-module `uart_rx_timeout` contains the counter, the comparator and `tout_pend`.
- The top level contains the THRE flag logic, the priority encoder and the output registers.

## Test plan
- **Reset and THRE.**
  - Stimulus: reset, then `thre` 0→1 with `etbei`=1.
  - Required: `iir_id`=0010 and `uart_intpt`=1 two cycles later.
  - Then `iir_rd`: `iir_id`=0001 and `uart_intpt`=0 next cycle, although `thre` stays 1.
- **Priority.**
  - Stimulus: `fe`=1, `elsi`=1, `dr`=`erbi`=1, `fifo_en`=0 together.
  - Required: `iir_id`=0110.
  - Clear `fe`: `iir_id`=0100 after one edge.
- **Trigger level.**
  - Stimulus: `fifo_en`=1, `dr`=1, `below_level`=1.
  - Required: `iir_id` stays 0001.
  - `below_level`→0: `iir_id`=0100.
- **Timeout.**
  - Stimulus: `tout_limit`=40, `rx_empty`=0, 40 `bit_tick` pulses with no push/pop.
  - Required: `iir_id`=1100.
  - A `rx_push` at tick 39 restarts the count, so no 1100 appears until 40 further ticks.
  - `rx_pop`: 1100 clears.
- **Simultaneous THRE events.**
  - Stimulus: `iir_rd` while `iir_id`=THRE, coincident with a new `thre` rising edge.
  - Required: `thre_pend` remains 1.
  - `thr_wr` alone clears it.
- **Modem status and mid-operation reset.**
  - Stimulus: `ddcd`=1, `edssi`=1.
  - Required: `iir_id`=0000 and `uart_intpt`=1.
  - Assert `rst` mid-count: all outputs return to reset values immediately.
